// File: rtl/fads_sorter_pkg.sv
// Shared definitions for the FADS sort-actuation stage: register map,
// FSM state encoding and the power-on values of the timing registers.
package fads_sorter_pkg;

    localparam logic [19:0] ADDR_CTRL   = 20'h00;
    localparam logic [19:0] ADDR_MIN_W  = 20'h04;
    localparam logic [19:0] ADDR_DELAY  = 20'h08;
    localparam logic [19:0] ADDR_PULSE  = 20'h0C;
    localparam logic [19:0] ADDR_N_DET  = 20'h10;
    localparam logic [19:0] ADDR_N_SORT = 20'h14;
    localparam logic [19:0] ADDR_N_DROP = 20'h18;
    localparam logic [19:0] ADDR_STATUS = 20'h1C;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        DELAY   = 2'd2,
        PULSE   = 2'd3
    } state_e;

    localparam int RST_MIN_W = 4;
    localparam int RST_DELAY = 1000;
    localparam int RST_PULSE = 500;

endpackage

// File: rtl/fads_sat_counter.sv
// 32-bit event counter that sticks at all-ones; clear takes priority over increment.
module fads_sat_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/red_pitaya_fads_sorter.sv
// FADS sort actuator: qualifies trigger width, waits the flight delay, then
// fires one fixed-length sort pulse; configuration and statistics on sys bus.
module red_pitaya_fads_sorter
    import fads_sorter_pkg::*;
#(
    parameter int CW = 24,
    parameter int WW = 16
) (
    input  logic        adc_clk_i,
    input  logic        adc_rst_i,
    input  logic        trig_i,
    output logic        sort_o,
    output logic        busy_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);

    logic          enable_q;
    logic [WW-1:0] min_w_q;
    logic [CW-1:0] delay_q;
    logic [CW-1:0] pulse_q;

    state_e        state_q;
    logic          trig_d_q;
    logic          sort_q;
    logic          busy_q;
    logic [WW-1:0] wcnt_q;
    logic [WW-1:0] min_lat_q;
    logic [CW-1:0] dcnt_q;
    logic [CW-1:0] d_lat_q;
    logic [CW-1:0] pcnt_q;
    logic [CW-1:0] p_lat_q;

    logic          ack_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rdata_d;

    logic [31:0]   n_det;
    logic [31:0]   n_sort;
    logic [31:0]   n_drop;

    logic [19:0]   addr;
    logic          rise;
    logic          qualify;
    logic          delay_done;
    logic          pulse_done;
    logic          clr_cnt;
    logic          det_inc;
    logic          sort_inc;
    logic          drop_inc;
    logic [WW-1:0] min_eff;
    logic [CW-1:0] pulse_eff;
    logic [WW:0]   wcnt_inc;
    logic          unused_bits;

    assign addr      = sys_addr[19:0];
    assign rise      = trig_i & ~trig_d_q;
    assign min_eff   = (min_w_q == '0) ? WW'(1) : min_w_q;
    assign pulse_eff = (pulse_q == '0) ? CW'(1) : pulse_q;
    assign wcnt_inc  = {1'b0, wcnt_q} + {{WW{1'b0}}, 1'b1};

    // IDLE qualifies on the edge itself only when one sample is enough.
    always_comb begin
        qualify = 1'b0;
        if (enable_q) begin
            if (state_q == IDLE) begin
                qualify = rise && (min_eff == WW'(1));
            end else if (state_q == QUALIFY) begin
                qualify = trig_i && (wcnt_inc >= {1'b0, min_lat_q});
            end
        end
    end

    assign delay_done = (state_q == DELAY) && (dcnt_q == d_lat_q);
    assign pulse_done = (state_q == PULSE) && (pcnt_q == p_lat_q);
    assign clr_cnt    = sys_wen && (addr == ADDR_CTRL) && sys_wdata[1];
    assign det_inc    = qualify;
    assign sort_inc   = enable_q && pulse_done;
    assign drop_inc   = rise && ((state_q == DELAY) || (state_q == PULSE));

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q   <= IDLE;
            trig_d_q  <= 1'b0;
            sort_q    <= 1'b0;
            busy_q    <= 1'b0;
            wcnt_q    <= '0;
            min_lat_q <= '0;
            dcnt_q    <= '0;
            d_lat_q   <= '0;
            pcnt_q    <= '0;
            p_lat_q   <= '0;
        end else begin
            trig_d_q <= trig_i;
            if (!enable_q) begin
                state_q <= IDLE;
                sort_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            busy_q    <= 1'b1;
                            wcnt_q    <= WW'(1);
                            min_lat_q <= min_eff;
                            state_q   <= qualify ? DELAY : QUALIFY;
                        end
                    end
                    QUALIFY: begin
                        if (!trig_i) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            wcnt_q  <= wcnt_inc[WW-1:0];
                            state_q <= qualify ? DELAY : QUALIFY;
                        end
                    end
                    DELAY: begin
                        if (delay_done) begin
                            state_q <= PULSE;
                            pcnt_q  <= CW'(1);
                            sort_q  <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q + CW'(1);
                        end
                    end
                    PULSE: begin
                        if (pulse_done) begin
                            state_q <= IDLE;
                            sort_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            pcnt_q <= pcnt_q + CW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // Timing is frozen at qualification so later writes only affect the next event.
                if (qualify) begin
                    d_lat_q <= delay_q;
                    p_lat_q <= pulse_eff;
                    dcnt_q  <= '0;
                end
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        case (addr)
            ADDR_CTRL:   rdata_d = {31'd0, enable_q};
            ADDR_MIN_W:  rdata_d = 32'(min_w_q);
            ADDR_DELAY:  rdata_d = 32'(delay_q);
            ADDR_PULSE:  rdata_d = 32'(pulse_q);
            ADDR_N_DET:  rdata_d = n_det;
            ADDR_N_SORT: rdata_d = n_sort;
            ADDR_N_DROP: rdata_d = n_drop;
            ADDR_STATUS: rdata_d = {29'd0, sort_q, state_q};
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            enable_q <= 1'b0;
            min_w_q  <= WW'(RST_MIN_W);
            delay_q  <= CW'(RST_DELAY);
            pulse_q  <= CW'(RST_PULSE);
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ack_q   <= sys_wen | sys_ren;
            rdata_q <= sys_ren ? rdata_d : '0;
            if (sys_wen) begin
                case (addr)
                    ADDR_CTRL:  enable_q <= sys_wdata[0];
                    ADDR_MIN_W: min_w_q  <= sys_wdata[WW-1:0];
                    ADDR_DELAY: delay_q  <= sys_wdata[CW-1:0];
                    ADDR_PULSE: pulse_q  <= sys_wdata[CW-1:0];
                    default: ;
                endcase
            end
        end
    end

    fads_sat_counter u_cnt_det (
        .clk_i (adc_clk_i),
        .rst_i (adc_rst_i),
        .inc_i (det_inc),
        .clr_i (clr_cnt),
        .cnt_o (n_det)
    );

    fads_sat_counter u_cnt_sort (
        .clk_i (adc_clk_i),
        .rst_i (adc_rst_i),
        .inc_i (sort_inc),
        .clr_i (clr_cnt),
        .cnt_o (n_sort)
    );

    fads_sat_counter u_cnt_drop (
        .clk_i (adc_clk_i),
        .rst_i (adc_rst_i),
        .inc_i (drop_inc),
        .clr_i (clr_cnt),
        .cnt_o (n_drop)
    );

    assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata};

    assign sort_o    = sort_q;
    assign busy_o    = busy_q;
    assign sys_ack   = ack_q;
    assign sys_rdata = rdata_q;
    assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
// Self-checking bench for red_pitaya_fads_sorter: directed scenarios plus
// randomized trigger trains compared against an event-level reference model.
module tb_red_pitaya_fads_sorter;

    localparam int          NMAX   = 400;
    localparam logic [31:0] BASE   = 32'h4060_0000;
    localparam logic [31:0] R_CTRL = 32'h00;
    localparam logic [31:0] R_MINW = 32'h04;
    localparam logic [31:0] R_DLY  = 32'h08;
    localparam logic [31:0] R_PLS  = 32'h0C;
    localparam logic [31:0] R_NDET = 32'h10;
    localparam logic [31:0] R_NSRT = 32'h14;
    localparam logic [31:0] R_NDRP = 32'h18;
    localparam logic [31:0] R_STAT = 32'h1C;

    logic        adc_clk_i;
    logic        adc_rst_i;
    logic        trig_i;
    logic        sort_o;
    logic        busy_o;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    int n_cmp = 0;
    int n_bad = 0;

    bit trig_pat [NMAX];
    bit exp_sort [NMAX];
    bit exp_busy [NMAX];
    bit act_sort [NMAX];
    int e_det, e_sort, e_drop;

    red_pitaya_fads_sorter dut (
        .adc_clk_i (adc_clk_i),
        .adc_rst_i (adc_rst_i),
        .trig_i    (trig_i),
        .sort_o    (sort_o),
        .busy_o    (busy_o),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_sel   (sys_sel),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    initial adc_clk_i = 1'b0;
    always #5 adc_clk_i = ~adc_clk_i;

    task automatic step();
        @(posedge adc_clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
        sys_addr  = BASE | off;
        sys_wdata = d;
        sys_wen   = 1'b1;
        step();
        sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] d,
                            output logic ack_pre, output logic ack, output logic ack_post);
        sys_addr = BASE | off;
        sys_ren  = 1'b1;
        ack_pre  = sys_ack;
        step();
        sys_ren  = 1'b0;
        d        = sys_rdata;
        ack      = sys_ack;
        step();
        ack_post = sys_ack;
    endtask

    task automatic read_counters(output logic [31:0] det, output logic [31:0] srt,
                                 output logic [31:0] drp);
        logic a0, a1, a2;
        bus_read(R_NDET, det, a0, a1, a2);
        bus_read(R_NSRT, srt, a0, a1, a2);
        bus_read(R_NDRP, drp, a0, a1, a2);
    endtask

    // Enable + clear counters, then program the timing registers.
    task automatic configure(input int mw, input int d, input int p);
        bus_write(R_CTRL, 32'd3);
        bus_write(R_MINW, 32'(mw));
        bus_write(R_DLY, 32'(d));
        bus_write(R_PLS, 32'(p));
        step();
        step();
    endtask

    task automatic clear_pattern();
        for (int k = 0; k < NMAX; k++) trig_pat[k] = 1'b0;
    endtask

    // Event-level reference: each accepted edge either fails its width test
    // or produces one sort window; edges landing in an active window are drops.
    task automatic model_run(input int mw, input int d, input int p, input int n);
        int free_t, m, pe, r, q, s0, s1;
        bit is_rise;
        for (int k = 0; k < NMAX; k++) begin
            exp_sort[k] = 1'b0;
            exp_busy[k] = 1'b0;
        end
        e_det = 0; e_sort = 0; e_drop = 0;
        free_t = 0;
        m  = (mw < 1) ? 1 : mw;
        pe = (p < 1) ? 1 : p;
        for (int t = 0; t < n; t++) begin
            is_rise = trig_pat[t] && (t == 0 || !trig_pat[t-1]);
            if (is_rise && t >= free_t) begin
                r = 0;
                while (t + r < n && trig_pat[t+r]) r++;
                if (r >= m) begin
                    q  = t + m - 1;
                    s0 = q + 2 + d;
                    s1 = q + 1 + d + pe;
                    e_det++;
                    e_sort++;
                    for (int c = t + 1; c <= s1 && c < n; c++) exp_busy[c] = 1'b1;
                    for (int c = s0; c <= s1 && c < n; c++) exp_sort[c] = 1'b1;
                    for (int c = q + 1; c <= s1 && c < n; c++)
                        if (trig_pat[c] && !trig_pat[c-1]) e_drop++;
                    free_t = s1 + 1;
                end else begin
                    for (int c = t + 1; c <= t + r && c < n; c++) exp_busy[c] = 1'b1;
                    free_t = t + r + 1;
                end
            end
        end
    endtask

    task automatic run_pattern(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            trig_i      = trig_pat[k];
            act_sort[k] = sort_o;
            n_cmp++;
            if (sort_o !== exp_sort[k]) begin
                n_bad++;
                $display("FAIL %s sort_o cycle %0d: got %b expected %b", tag, k, sort_o, exp_sort[k]);
            end
            n_cmp++;
            if (busy_o !== exp_busy[k]) begin
                n_bad++;
                $display("FAIL %s busy_o cycle %0d: got %b expected %b", tag, k, busy_o, exp_busy[k]);
            end
            step();
        end
        trig_i = 1'b0;
    endtask

    function automatic int first_high(input int n);
        for (int k = 0; k < n; k++) if (act_sort[k]) return k;
        return -1;
    endfunction

    function automatic int count_high(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (act_sort[k]) c++;
        return c;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        logic a0, a1, a2;
        adc_rst_i = 1'b1;
        repeat (3) step();
        adc_rst_i = 1'b0;
        n_cmp++;
        if ({sort_o, busy_o, sys_ack, sys_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset outputs: got %b expected 0000", {sort_o, busy_o, sys_ack, sys_err});
        end
        n_cmp++;
        if (sys_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset rdata: got %0h expected 0", sys_rdata);
        end
        bus_read(R_STAT, d, a0, a1, a2);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL reset status: got %0h expected 0", d);
        end
        // Enable defaults to 0, so a trigger must not start an event.
        trig_i = 1'b1;
        repeat (6) step();
        trig_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL disabled busy: got %b expected 0", busy_o);
        end
        step();
    endtask

    task automatic test_bus_defaults();
        logic [31:0] d;
        logic a0, a1, a2;
        logic [31:0] exp_v [4];
        logic [31:0] offs [4];
        offs[0] = R_MINW; exp_v[0] = 32'd4;
        offs[1] = R_DLY;  exp_v[1] = 32'd1000;
        offs[2] = R_PLS;  exp_v[2] = 32'd500;
        offs[3] = 32'h40; exp_v[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            bus_read(offs[i], d, a0, a1, a2);
            n_cmp++;
            if (d !== exp_v[i]) begin
                n_bad++;
                $display("FAIL default read %0h: got %0d expected %0d", offs[i], d, exp_v[i]);
            end
            n_cmp++;
            if ({a0, a1, a2} !== 3'b010) begin
                n_bad++;
                $display("FAIL ack timing %0h: got %b expected 010", offs[i], {a0, a1, a2});
            end
        end
        n_cmp++;
        if (sys_err !== 1'b0) begin
            n_bad++;
            $display("FAIL sys_err: got %b expected 0", sys_err);
        end
    endtask

    task automatic test_basic_sort();
        logic [31:0] det, srt, drp;
        clear_pattern();
        for (int k = 0; k < 8; k++) trig_pat[k] = 1'b1;
        configure(4, 10, 5);
        model_run(4, 10, 5, 40);
        run_pattern("basic", 40);
        n_cmp++;
        if (first_high(40) !== 15 || count_high(40) !== 5) begin
            n_bad++;
            $display("FAIL basic window: got first %0d count %0d expected 15 5", first_high(40), count_high(40));
        end
        read_counters(det, srt, drp);
        n_cmp++;
        if (det !== 32'(e_det) || srt !== 32'(e_sort)) begin
            n_bad++;
            $display("FAIL basic counters: got %0d %0d expected %0d %0d", det, srt, e_det, e_sort);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] det, srt, drp;
        clear_pattern();
        for (int k = 0; k < 3; k++) trig_pat[k] = 1'b1;
        configure(4, 10, 5);
        model_run(4, 10, 5, 30);
        run_pattern("glitch", 30);
        n_cmp++;
        if (count_high(30) !== 0) begin
            n_bad++;
            $display("FAIL glitch sort count: got %0d expected 0", count_high(30));
        end
        read_counters(det, srt, drp);
        n_cmp++;
        if (det !== 32'd0) begin
            n_bad++;
            $display("FAIL glitch N_DET: got %0d expected 0", det);
        end
    endtask

    task automatic test_drop();
        logic [31:0] det, srt, drp;
        clear_pattern();
        for (int k = 0; k < 5; k++) trig_pat[k] = 1'b1;
        for (int k = 9; k < 12; k++) trig_pat[k] = 1'b1;
        configure(4, 10, 5);
        model_run(4, 10, 5, 40);
        run_pattern("drop", 40);
        n_cmp++;
        if (count_high(40) !== 5) begin
            n_bad++;
            $display("FAIL drop sort count: got %0d expected 5", count_high(40));
        end
        read_counters(det, srt, drp);
        n_cmp++;
        if (drp !== 32'd1 || srt !== 32'd1) begin
            n_bad++;
            $display("FAIL drop counters: got drop %0d sort %0d expected 1 1", drp, srt);
        end
    endtask

    task automatic test_abort();
        logic [31:0] det, srt, drp, st;
        logic a0, a1, a2;
        configure(1, 2, 20);
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (sort_o !== 1'b1) begin
            n_bad++;
            $display("FAIL abort pre-write sort_o: got %b expected 1", sort_o);
        end
        bus_write(R_CTRL, 32'd0);
        n_cmp++;
        if (sort_o !== 1'b1) begin
            n_bad++;
            $display("FAIL abort landing sort_o: got %b expected 1", sort_o);
        end
        step();
        n_cmp++;
        if ({sort_o, busy_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort sort/busy: got %b expected 00", {sort_o, busy_o});
        end
        repeat (25) step();
        read_counters(det, srt, drp);
        n_cmp++;
        if (srt !== 32'd0 || det !== 32'd1) begin
            n_bad++;
            $display("FAIL abort counters: got sort %0d det %0d expected 0 1", srt, det);
        end
        bus_read(R_STAT, st, a0, a1, a2);
        n_cmp++;
        if (st[1:0] !== 2'd0) begin
            n_bad++;
            $display("FAIL abort status: got %0d expected 0", st[1:0]);
        end
    endtask

    task automatic test_degenerate();
        logic [31:0] det, srt, drp;
        clear_pattern();
        trig_pat[0] = 1'b1;
        configure(0, 0, 0);
        model_run(0, 0, 0, 12);
        run_pattern("degen", 12);
        n_cmp++;
        if (first_high(12) !== 2 || count_high(12) !== 1) begin
            n_bad++;
            $display("FAIL degen window: got first %0d count %0d expected 2 1", first_high(12), count_high(12));
        end
        read_counters(det, srt, drp);
        n_cmp++;
        if (det !== 32'd1) begin
            n_bad++;
            $display("FAIL degen N_DET: got %0d expected 1", det);
        end
    endtask

    task automatic test_clear_vs_inc();
        logic [31:0] d, det, srt, drp;
        logic a0, a1, a2;
        configure(1, 0, 3);
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        bus_read(R_NDET, d, a0, a1, a2);
        n_cmp++;
        if (d !== 32'd1) begin
            n_bad++;
            $display("FAIL clear setup N_DET: got %0d expected 1", d);
        end
        step();
        // Last PULSE cycle: N_SORT increments here, and the clear lands on it.
        bus_write(R_CTRL, 32'd2);
        step();
        read_counters(det, srt, drp);
        n_cmp++;
        if ({det, srt, drp} !== 96'd0) begin
            n_bad++;
            $display("FAIL clear wins: got %0d %0d %0d expected 0 0 0", det, srt, drp);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        logic a0, a1, a2;
        configure(1, 0, 1);
        force dut.u_cnt_det.cnt_q = 32'hFFFF_FFFE;
        step();
        step();
        release dut.u_cnt_det.cnt_q;
        bus_read(R_NDET, d, a0, a1, a2);
        n_cmp++;
        if (d !== 32'hFFFF_FFFE) begin
            n_bad++;
            $display("FAIL sat preload: got %0h expected fffffffe", d);
        end
        for (int i = 0; i < 2; i++) begin
            clear_pattern();
            trig_pat[0] = 1'b1;
            model_run(1, 0, 1, 10);
            run_pattern("sat", 10);
            bus_read(R_NDET, d, a0, a1, a2);
            n_cmp++;
            if (d !== 32'hFFFF_FFFF) begin
                n_bad++;
                $display("FAIL sat event %0d: got %0h expected ffffffff", i, d);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] det, srt, drp;
        int mw, d, p, t, len;
        for (int it = 0; it < 6; it++) begin
            mw = int'($urandom_range(0, 5));
            d  = int'($urandom_range(0, 12));
            p  = int'($urandom_range(0, 6));
            clear_pattern();
            t = 0;
            while (t < 250) begin
                t += int'($urandom_range(1, 20));
                len = int'($urandom_range(1, 8));
                for (int k = 0; k < len && t < 250; k++) begin
                    trig_pat[t] = 1'b1;
                    t++;
                end
            end
            configure(mw, d, p);
            model_run(mw, d, p, 300);
            run_pattern($sformatf("rand%0d", it), 300);
            read_counters(det, srt, drp);
            n_cmp++;
            if (det !== 32'(e_det) || srt !== 32'(e_sort) || drp !== 32'(e_drop)) begin
                n_bad++;
                $display("FAIL rand%0d counters: got %0d %0d %0d expected %0d %0d %0d",
                         it, det, srt, drp, e_det, e_sort, e_drop);
            end
        end
    endtask

    initial begin
        adc_rst_i = 1'b1;
        trig_i    = 1'b0;
        sys_addr  = '0;
        sys_wdata = '0;
        sys_sel   = 4'hF;
        sys_wen   = 1'b0;
        sys_ren   = 1'b0;
        test_reset();
        test_bus_defaults();
        test_basic_sort();
        test_glitch();
        test_drop();
        test_abort();
        test_degenerate();
        test_clear_vs_inc();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
